// File: rtl/cpu_fifo_responder_if.sv
// Producer/consumer bus for cpu_fifo_responder: write port, show-ahead read port and status.
interface cpu_fifo_responder_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             iWR_WRITE;
  logic [WIDTH-1:0] iWR_WRITEDATA;
  logic             oWR_WAITREQUEST;
  logic             iRD_READ;
  logic [WIDTH-1:0] oRD_READDATA;
  logic             oRD_WAITREQUEST;
  logic [LW-1:0]    oLEVEL;
  logic             oFULL;
  logic             oEMPTY;
  logic [15:0]      oUNDERFLOW_CNT;

  modport master (
    output iWR_WRITE, iWR_WRITEDATA, iRD_READ,
    input  oWR_WAITREQUEST, oRD_READDATA, oRD_WAITREQUEST,
    input  oLEVEL, oFULL, oEMPTY, oUNDERFLOW_CNT
  );

  modport slave (
    input  iWR_WRITE, iWR_WRITEDATA, iRD_READ,
    output oWR_WAITREQUEST, oRD_READDATA, oRD_WAITREQUEST,
    output oLEVEL, oFULL, oEMPTY, oUNDERFLOW_CNT
  );
endinterface

// File: rtl/cpu_fifo_responder.sv
// Single-clock FIFO between a writing and a reading bus master, zero-latency show-ahead read,
// optional non-blocking reads on empty that return EMPTY_WORD and count underflows.
module cpu_fifo_responder #(
  parameter int              DEPTH      = 16,
  parameter int              WIDTH      = 32,
  parameter int              NONBLOCK   = 1,
  parameter logic [WIDTH-1:0] EMPTY_WORD = 32'hffffffff
) (
  input logic                 iCLK,
  input logic                 iRESET,
  cpu_fifo_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level;
  logic [LW-1:0]    level_nxt;
  logic             full;
  logic             empty;
  logic [15:0]      underflow_cnt;

  logic rd_stall;
  logic rd_accept;
  logic rd_pop;
  logic wr_stall;
  logic wr_accept;
  logic underflow;

  // A read on empty is accepted in non-blocking mode but never pops: no write bypass.
  assign rd_stall  = (NONBLOCK == 0) && bus.iRD_READ && empty;
  assign rd_accept = bus.iRD_READ && !rd_stall;
  assign rd_pop    = rd_accept && !empty;
  assign underflow = (NONBLOCK != 0) && bus.iRD_READ && empty;
  assign wr_stall  = bus.iWR_WRITE && full && !rd_accept;
  assign wr_accept = bus.iWR_WRITE && !wr_stall;

  always_comb begin
    // NOTE: default assignment first so no path leaves level_nxt unassigned (no latch).
    level_nxt = level;
    case ({wr_accept, rd_pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      full          <= 1'b0;
      empty         <= 1'b1;
      underflow_cnt <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + AW'(1);
      if (rd_pop)    rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
      full  <= (level_nxt == LW'(DEPTH));
      empty <= (level_nxt == '0);
      if (underflow && (underflow_cnt != 16'hffff))
        underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

  // NOTE: storage is deliberately not reset; empty masks stale words from the read port.
  always_ff @(posedge iCLK) begin
    if (wr_accept) mem[wr_ptr] <= bus.iWR_WRITEDATA;
  end

  assign bus.oRD_READDATA    = empty ? EMPTY_WORD : mem[rd_ptr];
  assign bus.oRD_WAITREQUEST = rd_stall;
  assign bus.oWR_WAITREQUEST = wr_stall;
  assign bus.oLEVEL          = level;
  assign bus.oFULL           = full;
  assign bus.oEMPTY          = empty;
  assign bus.oUNDERFLOW_CNT  = underflow_cnt;
endmodule
